// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one input bit per clock).
// Result and overflow flag are registered and held between conversions for the display driver.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 32,
  parameter int BCD_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    binary,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]           state;
  logic [BIN_WIDTH-1:0] work;
  logic [BCD_W-1:0]     acc;
  logic                 sticky;
  logic [CNT_W-1:0]     cnt;

  logic [BCD_W-1:0]     acc_adj;
  logic [BCD_W-1:0]     acc_next;
  logic                 shift_out;

  // Every digit >= 5 is pre-corrected so the following doubling carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    acc_adj   = add3_all(acc);
    shift_out = acc_adj[BCD_W-1];
    acc_next  = {acc_adj[BCD_W-2:0], work[BIN_WIDTH-1]};
  end

  // A bit leaving the top digit is a carry worth 10^BCD_DIGITS, so it marks overflow for good.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
      ovf    <= 1'b0;
      work   <= '0;
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= binary;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          acc    <= acc_next;
          work   <= work << 1;
          sticky <= sticky | shift_out;
          if (cnt == LAST_CNT) begin
            bcd   <= acc_next;
            ovf   <= sticky | shift_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed corner cases plus random values against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int BIN_WIDTH  = 32;
  localparam int BCD_DIGITS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] binary;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bin_to_bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .ovf    (ovf)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [31:0] r;
    x = v;
    r = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] v);
    return (64'(v) >= 64'd100000000);
  endfunction

  // Called at a negedge; drives start for one edge. spur_at pulses a second start while busy,
  // rst_at aborts the conversion with reset on that cycle.
  task automatic run_conv(input logic [31:0] val, input int spur_at, input int rst_at,
                          output int done_at);
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    bit          hold_ok;
    bit          got;
    int          busy_n;
    int          n_done;
    prev_bcd = bcd;
    prev_ovf = ovf;
    hold_ok  = 1'b1;
    got      = 1'b0;
    busy_n   = 0;
    done_at  = 0;
    start    = 1'b1;
    binary   = val;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start  = 1'b0;
      binary = $urandom;
      if (i == spur_at) begin
        start  = 1'b1;
        binary = 32'd999;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) begin
          @(negedge clk);
          if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        return;
      end
      if (done) begin
        got     = 1'b1;
        done_at = cyc;
        check("latency", i, BIN_WIDTH + 1);
        break;
      end
      if (busy) busy_n++;
      if (bcd !== prev_bcd || ovf !== prev_ovf) hold_ok = 1'b0;
    end
    check("done_seen", got, 1);
    check("busy_cycles", busy_n, BIN_WIDTH);
    check("hold_during_conv", hold_ok, 1);
    check("bcd", bcd, ref_bcd(val));
    check("ovf", ovf, ref_ovf(val));
  endtask

  task automatic quiet(input int n);
    int n_done;
    n_done = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_extra_done", n_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int d1, d2, dx;
    logic [31:0] v;
    reset  = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    run_conv(32'd0, 0, 0, dx);
    quiet(3);
    run_conv(32'd12345678, 0, 0, dx);
    quiet(2);

    run_conv(32'd99999999, 0, 0, d1);
    run_conv(32'd100000000, 0, 0, d2);
    check("b2b_spacing", d2 - d1, BIN_WIDTH + 1);
    quiet(2);

    run_conv(32'hFFFF_FFFF, 0, 0, dx);
    quiet(2);

    run_conv(32'd5, 0, 0, dx);
    quiet(2);
    run_conv(32'd7, 10, 0, dx);
    quiet(40);

    run_conv(32'd42, 0, 15, dx);
    run_conv(32'd42, 0, 0, dx);

    for (int k = 0; k < 20; k++) begin
      case (k % 4)
        0: v = $urandom;
        1: v = $urandom_range(99999999);
        2: v = 32'd99999990 + 32'($urandom_range(20));
        default: v = $urandom_range(9999);
      endcase
      run_conv(v, (k % 3 == 0) ? int'($urandom_range(2, 30)) : 0, 0, dx);
      if (k % 2 == 0) quiet(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
